// File: rtl/sdp_xfer_scheduler.sv
// Round-robin command scheduler in front of the single SDP driver.
// Splits each granted transfer into CHUNK_BYTES-sized driver transactions.
module sdp_xfer_scheduler #(
   parameter  int NUM_REQ        = 4,
   parameter  int AXI_ADDR_WIDTH = 64,
   parameter  int C_LENGTH_WIDTH = 32,
   parameter  int CHUNK_BYTES    = 4096,
   localparam int REQ_ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*32-1:0]             req_command,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_storage_addr,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_memory_addr,
   input  logic [NUM_REQ*C_LENGTH_WIDTH-1:0] req_len,
   output logic [NUM_REQ-1:0]                cmpl_valid,
   output logic                              drv_start,
   input  logic                              drv_done,
   output logic [31:0]                       drv_command,
   output logic [AXI_ADDR_WIDTH-1:0]         drv_storage_addr,
   output logic [AXI_ADDR_WIDTH-1:0]         drv_memory_addr,
   output logic [C_LENGTH_WIDTH-1:0]         drv_file_len,
   output logic                              busy,
   output logic [REQ_ID_WIDTH-1:0]           active_id
);

   // One-hot so that drv_start and busy come straight off state flops.
   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      ISSUE = 4'b0010,
      WAIT  = 4'b0100,
      CMPL  = 4'b1000
   } state_t;

   localparam logic [C_LENGTH_WIDTH-1:0] CHUNK = C_LENGTH_WIDTH'(CHUNK_BYTES);

   state_t                      state, state_nxt;
   logic [REQ_ID_WIDTH-1:0]     rr_ptr, grant;
   logic                        grant_vld;
   logic [31:0]                 cmd_q, cmd_in;
   logic [AXI_ADDR_WIDTH-1:0]   saddr_q, maddr_q, saddr_in, maddr_in;
   logic [C_LENGTH_WIDTH-1:0]   remaining, chunk, rem_next, len_in;

   function automatic logic [REQ_ID_WIDTH-1:0] wrap_idx(input int v);
      return REQ_ID_WIDTH'(v % NUM_REQ);
   endfunction

   function automatic logic [C_LENGTH_WIDTH-1:0] clip(input logic [C_LENGTH_WIDTH-1:0] v);
      return (v > CHUNK) ? CHUNK : v;
   endfunction

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_vld && req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
            grant     = wrap_idx(int'(rr_ptr) + k);
            grant_vld = 1'b1;
         end
      end
   end

   assign cmd_in   = req_command[32*grant +: 32];
   assign saddr_in = req_storage_addr[AXI_ADDR_WIDTH*grant +: AXI_ADDR_WIDTH];
   assign maddr_in = req_memory_addr[AXI_ADDR_WIDTH*grant +: AXI_ADDR_WIDTH];
   assign len_in   = req_len[C_LENGTH_WIDTH*grant +: C_LENGTH_WIDTH];
   assign rem_next = remaining - chunk;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = (len_in == '0) ? CMPL : ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (drv_done) state_nxt = (rem_next == '0) ? CMPL : ISSUE;
         CMPL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      cmpl_valid = '0;
      if (state == IDLE && grant_vld) req_ready[grant] = 1'b1;
      if (state == CMPL) cmpl_valid[active_id] = 1'b1;
      drv_start = state[1];
      busy      = !state[0];
   end

   // chunk is precomputed on entry to ISSUE so it is a flop while driven out.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q     <= '0;
         saddr_q   <= '0;
         maddr_q   <= '0;
         remaining <= '0;
         chunk     <= '0;
         active_id <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: if (grant_vld) begin
               cmd_q     <= cmd_in;
               saddr_q   <= saddr_in;
               maddr_q   <= maddr_in;
               remaining <= len_in;
               chunk     <= clip(len_in);
               active_id <= grant;
            end
            WAIT: if (drv_done) begin
               remaining <= rem_next;
               saddr_q   <= saddr_q + AXI_ADDR_WIDTH'(chunk);
               maddr_q   <= maddr_q + AXI_ADDR_WIDTH'(chunk);
               chunk     <= clip(rem_next);
            end
            CMPL: rr_ptr <= wrap_idx(int'(active_id) + 1);
            default: ;
         endcase
      end
   end

   assign drv_command      = cmd_q;
   assign drv_storage_addr = saddr_q;
   assign drv_memory_addr  = maddr_q;
   assign drv_file_len     = chunk;

endmodule

// File: tb/tb_sdp_xfer_scheduler.sv
// Bench for sdp_xfer_scheduler: transaction-level timing model plus directed transfers.
module tb_sdp_xfer_scheduler;
   localparam int NR = 4;
   localparam int AW = 64;
   localparam int LW = 32;
   localparam int CB = 4096;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid, req_ready, cmpl_valid;
   logic [NR*32-1:0]  req_command;
   logic [NR*AW-1:0]  req_storage_addr, req_memory_addr;
   logic [NR*LW-1:0]  req_len;
   logic              drv_start, drv_done, busy;
   logic              auto_done = 1'b0, spur_done = 1'b0;
   logic [31:0]       drv_command;
   logic [AW-1:0]     drv_storage_addr, drv_memory_addr;
   logic [LW-1:0]     drv_file_len;
   logic [1:0]        active_id;

   logic [31:0]       r_cmd [NR];
   logic [AW-1:0]     r_sa  [NR];
   logic [AW-1:0]     r_ma  [NR];
   logic [LW-1:0]     r_len [NR];
   int                posted [NR] = '{default: 0};
   int                taken  [NR] = '{default: 0};
   int                cmpl_cnt [NR] = '{default: 0};

   int total = 0, bad = 0;
   int cyc = 0, start_cnt = 0;
   int last_done_cyc = -1, last_cmpl_cyc = -1, last_acc_cyc = -1;
   logic [LW-1:0] st_len [$];
   logic [AW-1:0] st_sa [$], st_ma [$];
   logic [31:0]   st_cmd [$];
   int            grant_q [$];

   // model state
   logic          m_busy = 1'b0, m_wait = 1'b0;
   int            m_rr = 0, m_owner = 0, m_start_at = -1, m_cmpl_at = -1;
   logic [LW-1:0] m_rem, e_len = '0;
   logic [AW-1:0] e_sa = '0, e_ma = '0;
   logic [31:0]   e_cmd = '0;

   assign drv_done = auto_done | spur_done;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_command[32*i +: 32]      = r_cmd[i];
         req_storage_addr[AW*i +: AW] = r_sa[i];
         req_memory_addr[AW*i +: AW]  = r_ma[i];
         req_len[LW*i +: LW]          = r_len[i];
      end
   end

   sdp_xfer_scheduler #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .C_LENGTH_WIDTH(LW),
                        .CHUNK_BYTES(CB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_command(req_command), .req_storage_addr(req_storage_addr),
      .req_memory_addr(req_memory_addr), .req_len(req_len), .cmpl_valid(cmpl_valid),
      .drv_start(drv_start), .drv_done(drv_done), .drv_command(drv_command),
      .drv_storage_addr(drv_storage_addr), .drv_memory_addr(drv_memory_addr),
      .drv_file_len(drv_file_len), .busy(busy), .active_id(active_id));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [LW-1:0] cmin(input logic [LW-1:0] r);
      return (r > LW'(CB)) ? LW'(CB) : r;
   endfunction

   function automatic int first_req();
      for (int k = 0; k < NR; k++)
         if (req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
      return -1;
   endfunction

   // compare, observe, then advance the model with this cycle's inputs
   always @(negedge clk) begin
      logic [NR-1:0] er, ec;
      int g;
      if (cyc > 0) begin
         er = '0;
         ec = '0;
         g  = first_req();
         if (!m_busy && g >= 0) er[g] = 1'b1;
         if (cyc == m_cmpl_at) ec[m_owner] = 1'b1;
         check("drv_start", 64'(drv_start), 64'(cyc == m_start_at));
         check("cmpl_valid", 64'(cmpl_valid), 64'(ec));
         check("busy", 64'(busy), 64'(m_busy));
         check("req_ready", 64'(req_ready), 64'(er));
         if (m_busy) check("active_id", 64'(active_id), 64'(m_owner));
         if (cyc == m_start_at || m_wait) begin
            check("drv_file_len", 64'(drv_file_len), 64'(e_len));
            check("drv_storage_addr", drv_storage_addr, e_sa);
            check("drv_memory_addr", drv_memory_addr, e_ma);
            check("drv_command", 64'(drv_command), 64'(e_cmd));
         end
         if (drv_start === 1'b1) begin
            start_cnt++;
            st_len.push_back(drv_file_len);
            st_sa.push_back(drv_storage_addr);
            st_ma.push_back(drv_memory_addr);
            st_cmd.push_back(drv_command);
         end
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i] === 1'b1) begin
               grant_q.push_back(i);
               last_acc_cyc = cyc;
            end
            if (cmpl_valid[i] === 1'b1) begin
               cmpl_cnt[i]++;
               last_cmpl_cyc = cyc;
            end
         end
         if (drv_done) last_done_cyc = cyc;
      end
      if (rst) begin
         m_busy = 1'b0; m_wait = 1'b0; m_rr = 0;
         m_start_at = -1; m_cmpl_at = -1;
         e_len = '0; e_sa = '0; e_ma = '0; e_cmd = '0;
      end else if (!m_busy) begin
         g = first_req();
         if (g >= 0) begin
            m_owner = g; m_busy = 1'b1;
            e_cmd = r_cmd[g]; e_sa = r_sa[g]; e_ma = r_ma[g];
            m_rem = r_len[g]; e_len = cmin(m_rem);
            if (m_rem == '0) m_cmpl_at = cyc + 1;
            else             m_start_at = cyc + 1;
         end
      end else if (cyc == m_start_at) begin
         m_wait = 1'b1;
      end else if (m_wait && drv_done) begin
         m_wait = 1'b0;
         m_rem  = m_rem - e_len;
         e_sa   = e_sa + AW'(e_len);
         e_ma   = e_ma + AW'(e_len);
         if (m_rem != '0) begin
            e_len = cmin(m_rem);
            m_start_at = cyc + 1;
         end else begin
            m_cmpl_at = cyc + 1;
         end
      end else if (cyc == m_cmpl_at) begin
         m_busy = 1'b0;
         m_rr = (m_owner + 1) % NR;
      end
      cyc++;
   end

   // driver stand-in: done 3 cycles after each start
   initial begin
      forever begin
         @(negedge clk);
         if (drv_start === 1'b1) begin
            repeat (3) @(posedge clk);
            #1 auto_done = 1'b1;
            @(posedge clk);
            #1 auto_done = 1'b0;
         end
      end
   end

   // requesters: raise valid for each posted command, drop it after accept
   initial begin
      logic [NR-1:0] acc;
      req_valid = '0;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               req_valid[i] = 1'b0;
               taken[i]++;
            end
            if (!req_valid[i] && taken[i] < posted[i]) req_valid[i] = 1'b1;
         end
      end
   end

   task automatic set_req(input int i, input logic [31:0] c, input logic [AW-1:0] sa,
                          input logic [AW-1:0] ma, input logic [LW-1:0] len);
      r_cmd[i] = c; r_sa[i] = sa; r_ma[i] = ma; r_len[i] = len;
      posted[i]++;
   endtask

   task automatic wait_cmpl(input int i, input int target);
      int n = 0;
      while (cmpl_cnt[i] < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("cmpl_wait_req%0d", i), 64'(cmpl_cnt[i] >= target), 64'd1);
   endtask

   initial begin
      int b, c0, sc, ga, n;
      rst = 1'b1;
      for (int i = 0; i < NR; i++) begin
         r_cmd[i] = '0; r_sa[i] = '0; r_ma[i] = '0; r_len[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_start", 64'(drv_start), 64'd0);
      check("reset_cmpl", 64'(cmpl_valid), 64'd0);
      check("reset_ready", 64'(req_ready), 64'd0);
      check("reset_len", 64'(drv_file_len), 64'd0);
      check("reset_saddr", drv_storage_addr, 64'd0);
      check("reset_id", 64'(active_id), 64'd0);

      // all four valid from reset; requester 1 re-posts after its completion
      for (int i = 0; i < NR; i++) set_req(i, 32'(i), AW'(i * 'h100), AW'('h4000 + i * 'h100), 'h10);
      wait_cmpl(1, 1);
      set_req(1, 32'h7, 'h500, 'h600, 'h10);
      wait_cmpl(1, 2);
      check("arb_count", 64'(grant_q.size()), 64'd5);
      check("arb_g0", 64'(grant_q[0]), 64'd0);
      check("arb_g1", 64'(grant_q[1]), 64'd1);
      check("arb_g2", 64'(grant_q[2]), 64'd2);
      check("arb_g3", 64'(grant_q[3]), 64'd3);
      check("arb_g4", 64'(grant_q[4]), 64'd1);
      repeat (3) @(negedge clk);

      // single get
      b = st_len.size();
      c0 = cmpl_cnt[0];
      set_req(0, 32'h0, 'h1000, 'h8000, 'h100);
      wait_cmpl(0, c0 + 1);
      check("get_starts", 64'(st_len.size() - b), 64'd1);
      check("get_len", 64'(st_len[b]), 64'h100);
      check("get_saddr", st_sa[b], 64'h1000);
      check("get_maddr", st_ma[b], 64'h8000);
      check("get_cmd", 64'(st_cmd[b]), 64'h0);
      check("get_cmpl_lat", 64'(last_cmpl_cyc - last_done_cyc), 64'd1);
      repeat (3) @(negedge clk);

      // put of 10000 bytes in three chunks
      b = st_len.size();
      c0 = cmpl_cnt[1];
      set_req(1, 32'h1, 'h2000, 'h10000, 10000);
      wait_cmpl(1, c0 + 1);
      repeat (5) @(negedge clk);
      check("put_starts", 64'(st_len.size() - b), 64'd3);
      check("put_len0", 64'(st_len[b]), 64'd4096);
      check("put_len1", 64'(st_len[b+1]), 64'd4096);
      check("put_len2", 64'(st_len[b+2]), 64'd1808);
      check("put_sa1", st_sa[b+1], 64'h3000);
      check("put_sa2", st_sa[b+2], 64'h4000);
      check("put_ma2", st_ma[b+2], 64'h12000);
      check("put_cmd2", 64'(st_cmd[b+2]), 64'h1);
      check("put_one_cmpl", 64'(cmpl_cnt[1]), 64'(c0 + 1));

      // memory address wrap
      b = st_len.size();
      c0 = cmpl_cnt[3];
      set_req(3, 32'h2, 'h0, 64'hFFFF_FFFF_FFFF_F000, 8192);
      wait_cmpl(3, c0 + 1);
      check("wrap_starts", 64'(st_len.size() - b), 64'd2);
      check("wrap_ma0", st_ma[b], 64'hFFFF_FFFF_FFFF_F000);
      check("wrap_ma1", st_ma[b+1], 64'h0);
      repeat (3) @(negedge clk);

      // spurious done while idle
      sc = start_cnt;
      @(posedge clk);
      #1 spur_done = 1'b1;
      @(posedge clk);
      #1 spur_done = 1'b0;
      repeat (2) @(negedge clk);
      check("spur_busy", 64'(busy), 64'd0);
      check("spur_nostart", 64'(start_cnt), 64'(sc));

      // zero-length on requester 2
      sc = start_cnt;
      c0 = cmpl_cnt[2];
      set_req(2, 32'h5, 'h100, 'h200, 0);
      wait_cmpl(2, c0 + 1);
      repeat (3) @(negedge clk);
      check("zero_lat", 64'(last_cmpl_cyc - last_acc_cyc), 64'd1);
      check("zero_nostart", 64'(start_cnt), 64'(sc));

      // reset in WAIT of a three-chunk transfer
      sc = start_cnt;
      c0 = cmpl_cnt[2];
      set_req(2, 32'h9, 'h40, 'h80, 10000);
      n = 0;
      while (start_cnt == sc && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_xfer_started", 64'(start_cnt), 64'(sc + 1));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_start", 64'(drv_start), 64'd0);
      check("rst_cmpl", 64'(cmpl_valid), 64'd0);
      check("rst_len", 64'(drv_file_len), 64'd0);
      check("rst_saddr", drv_storage_addr, 64'd0);
      check("rst_maddr", drv_memory_addr, 64'd0);
      check("rst_cmd", 64'(drv_command), 64'd0);
      check("rst_id", 64'(active_id), 64'd0);
      repeat (8) @(negedge clk);
      check("rst_no_cmpl", 64'(cmpl_cnt[2]), 64'(c0));
      ga = grant_q.size();
      set_req(3, 32'h3, 'h0, 'h0, 'h20);
      set_req(1, 32'h1, 'h0, 'h0, 'h20);
      wait_cmpl(3, cmpl_cnt[3] + 1);
      check("post_rst_g0", 64'(grant_q[ga]), 64'd1);
      check("post_rst_g1", 64'(grant_q[ga+1]), 64'd3);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: no finish by cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sdp_xfer_scheduler.md
# sdp_xfer_scheduler

Multi-requester command scheduler in front of the SDP driver. It accepts get/put transfer commands from NUM_REQ independent requesters and arbitrates between them round-robin. Each accepted transfer is split into chunks of at most CHUNK_BYTES, and each chunk is issued to the driver as one start/done transaction. When the last chunk finishes, the scheduler returns a one-cycle completion pulse to the owning requester. It sits between the host/control register layer and the single SDP driver instance, and is the only block that drives that driver's start, command, address and length inputs.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- AXI_ADDR_WIDTH, 64: address width.
- C_LENGTH_WIDTH, 32: byte-length width.
- CHUNK_BYTES, 4096: maximum bytes per driver transaction; must be a power of two and less than 2^C_LENGTH_WIDTH.
- REQ_ID_WIDTH, $clog2(NUM_REQ): derived, not overridden.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, NUM_REQ: per-requester command valid.
- req_ready, out, NUM_REQ: per-requester accept, one-hot or zero.
- req_command, in, NUM_REQ*32: command per requester (0 = get, nonzero = put), requester i at bits [32*i +: 32].
- req_storage_addr, in, NUM_REQ*AXI_ADDR_WIDTH: storage address per requester.
- req_memory_addr, in, NUM_REQ*AXI_ADDR_WIDTH: memory address per requester.
- req_len, in, NUM_REQ*C_LENGTH_WIDTH: byte length per requester.
- cmpl_valid, out, NUM_REQ: one-cycle completion pulse to the owning requester.
- drv_start, out, 1: driver start pulse.
- drv_done, in, 1: driver done pulse.
- drv_command, out, 32: command to driver.
- drv_storage_addr, out, AXI_ADDR_WIDTH: storage address to driver.
- drv_memory_addr, out, AXI_ADDR_WIDTH: memory address to driver.
- drv_file_len, out, C_LENGTH_WIDTH: chunk length to driver.
- busy, out, 1: high whenever the state is not IDLE.
- active_id, out, REQ_ID_WIDTH: index of the granted requester; valid while busy.

## Operation
The scheduler is a state machine with states IDLE, ISSUE, WAIT and CMPL.

IDLE:
- If any req_valid is high, grant the first valid requester found searching upward from rr_ptr, wrapping modulo NUM_REQ.
- Raise req_ready[grant] combinationally in that same cycle.
- Capture command, both addresses, remaining = req_len and active_id = grant.
- Go to ISSUE, or to CMPL if req_len == 0. A zero-length request never touches the driver.

ISSUE:
- Set chunk = min(remaining, CHUNK_BYTES).
- drv_start = 1 for exactly this cycle.
- drv_file_len = chunk.
- Go to WAIT.

WAIT:
- Hold every drv_* field stable.
- On drv_done:
  - remaining -= chunk.
  - storage_addr += chunk and memory_addr += chunk, both modulo 2^AXI_ADDR_WIDTH (wrap silently).
  - Go to ISSUE if the new remaining is nonzero, otherwise go to CMPL.

CMPL:
- cmpl_valid[active_id] = 1 for exactly this cycle.
- rr_ptr = (active_id + 1) mod NUM_REQ.
- Go to IDLE.

Rules and boundary cases:
- Requesters hold req_valid and all request fields stable until req_ready. A requester may present its next command in the cycle after its completion pulse.
- drv_command is passed through unmodified for all chunks of a transfer.
- drv_done outside WAIT is ignored: no state change and no counter update.
- drv_done in the same cycle drv_start is high cannot occur, because the driver needs at least 3 cycles. Nothing needs to be added to handle it.
- req_valid deasserting while not granted has no effect. Arbitration only samples in IDLE.
- Remaining-length arithmetic is in C_LENGTH_WIDTH bits; chunk is never larger than remaining, so it never underflows.
- Reset mid-transfer:
  - State returns to IDLE and rr_ptr returns to 0.
  - No cmpl_valid is emitted and the in-flight command is dropped.
  - The driver is reset by the same system reset.

## Timing
- Reset values: req_ready = 0, cmpl_valid = 0, drv_start = 0, all drv_* fields = 0, busy = 0, active_id = 0, rr_ptr = 0.
- All outputs are registered except req_ready, which is a combinational function of state, req_valid and rr_ptr.
- Accept at cycle t (req_valid & req_ready): drv_start is high at t+1.
- drv_done at cycle d, more chunks remaining: next drv_start at d+1.
- drv_done at cycle d, last chunk: cmpl_valid at d+1, IDLE at d+2, next accept possible at d+2.
- Zero-length accept at t: cmpl_valid at t+1, and the driver is never started.
- Chunk count per transfer is ceil(len / CHUNK_BYTES). The last chunk carries len mod CHUNK_BYTES bytes, or CHUNK_BYTES if that remainder is 0.

## Test plan
- Single get, requester 0, len = 0x100, storage 0x1000, memory 0x8000 -> one drv_start with file_len 0x100, storage 0x1000, memory 0x8000, command 0. cmpl_valid[0] one cycle after drv_done.
- Put, len = 10000, CHUNK_BYTES = 4096 -> three drv_starts with lengths 4096, 4096, 1808. Addresses advance by 4096 each time. Exactly one cmpl_valid.
- Requesters 0..3 all valid from reset -> grants in order 0, 1, 2, 3. Requester 1 re-raising valid after its completion is granted only after 2 and 3.
- len = 0 on requester 2 -> req_ready at t, cmpl_valid[2] at t+1, drv_start never asserted.
- Memory address 0xFFFF_FFFF_FFFF_F000, len 8192 -> second chunk memory address 0x0 (wrap). Spurious drv_done in IDLE -> no state change.
- rst asserted during WAIT of a 3-chunk transfer -> all outputs 0 the next cycle, no cmpl_valid. A new request after reset is granted starting from requester 0.
